phasefifo_dpram: RTL and testbench
==================================

Name: phasefifo_dpram

Overview:
- Single-clock simple dual-port RAM: one write port (A), one read port (B).
- Read port has a registered address and a registered output.
- Port B may be narrower than port A (mixed-width mode) so a DDR-style 2:1 phase FIFO can read half-words.
- Sits underneath the PCIe phase FIFO as its storage element: the write pointer drives port A, the read pointer drives port B.

Parameters:
- WIDTH_A, 20, write data width (bits).
- WIDTHAD_A, 4, write address width; depth is 2**WIDTHAD_A words.
- WIDTH_B, 20, read data width; must equal WIDTH_A or WIDTH_A/2.
- WIDTHAD_B, 4, read address width; must satisfy WIDTH_A*2**WIDTHAD_A == WIDTH_B*2**WIDTHAD_B.
- OUTDATA_REG_B, 1, 1 = registered q_b (2-cycle read latency); 0 = q_b straight from array (1-cycle latency).

Ports:
- clock0, in, 1, single clock for both ports; all state changes on its rising edge.
- npor, in, 1, asynchronous active-low reset.
- wren_a, in, 1, write enable for port A.
- address_a, in, WIDTHAD_A, write address.
- data_a, in, WIDTH_A, write data.
- rden_b, in, 1, read enable for port B.
- addressstall_b, in, 1, when 1, the port-B address register holds its value.
- address_b, in, WIDTHAD_B, read address.
- q_b, out, WIDTH_B, read data.

Behaviour:
- Reset (npor=0, asynchronous):
  - Clears the port-B address register and the q_b output register to 0; q_b=0 while npor is low.
  - Memory array is not reset; contents are retained across reset.
  - Reset deassertion is taken synchronously by the parent; the block has no internal synchronizer.
- Write:
  - On a rising edge with wren_a=1, mem[address_a] <= data_a (full WIDTH_A word).
  - wren_a=0: no write.
  - Writes are not gated by npor; an array update still occurs while npor is low.
- Read address register: on a rising edge with npor=1 and addressstall_b=0, addr_b_r <= address_b; otherwise it holds.
- Array read (combinational from addr_b_r):
  - Equal width: word = mem[addr_b_r].
  - Half width (WIDTH_B = WIDTH_A/2): word = mem[addr_b_r >> 1]; addr_b_r[0]=0 selects bits [WIDTH_B-1:0], addr_b_r[0]=1 selects bits [WIDTH_A-1:WIDTH_B].
- Output:
  - OUTDATA_REG_B=1: on a rising edge with npor=1 and rden_b=1, q_b <= array read; rden_b=0 holds q_b.
    - Latency: address_b presented before edge N, data on q_b after edge N+1 (2 clocks).
  - OUTDATA_REG_B=0: q_b = array read gated by rden_b, holding the last value when rden_b=0; 1-clock latency.
- Read-during-write to the same location on the same edge:
  - The output register captures the OLD contents.
  - New data is visible on the next read cycle.
- Address wrap-around: addresses are modulo depth; no out-of-range handling is needed because widths are exact.
- Illegal parameter combinations (width ratio not 1 or 2, total bits unequal) are flagged by an elaboration-time check.

Test Plan:
- Equal width (defaults):
  - Stimulus: reset, write mem[i]=i*0x111 for i=0..15, then sweep address_b 0..15 with rden_b=1.
  - Response: q_b = i*0x111 exactly two clocks after each address; q_b=0 during and right after reset.
- Half width (WIDTHAD_A=3, WIDTH_B=10, WIDTHAD_B=4):
  - Stimulus: write mem[2]=0xABCDE (20 bits), then read address_b 4 and 5.
  - Response: q_b=0x0DE then 0x2AF (low half, then high half).
- Read-during-write:
  - Stimulus: mem[5]=0x11111; hold address_b=5; on the same edge, write 0x22222 to address 5.
  - Response: that edge returns 0x11111; the following edge returns 0x22222.
- Stall and enables:
  - Stimulus: assert addressstall_b while changing address_b; then set rden_b=0.
  - Response: q_b stays at the data of the stalled address; with rden_b=0, q_b holds its last value.
- Mid-operation reset:
  - Stimulus: pulse npor low for half a cycle during streaming reads.
  - Response: q_b goes to 0 immediately (asynchronous); after release, reads of earlier-written locations return pre-reset contents.
- Continuous phase-FIFO traffic:
  - Stimulus: write pointer starting at 4 and read pointer starting at 0, both incrementing every clock with wren_a=1.
  - Response: each read returns the word written 4 clocks earlier with no corruption across 100 wraps.

Source files
------------

// File: rtl/phasefifo_dpram.sv
// phasefifo_dpram: simple dual-port RAM (write port A, registered-address read port B, optional half-width reads)
module phasefifo_dpram #(
  parameter int WIDTH_A       = 20,
  parameter int WIDTHAD_A     = 4,
  parameter int WIDTH_B       = 20,
  parameter int WIDTHAD_B     = 4,
  parameter int OUTDATA_REG_B = 1
) (
  input  logic                 clock0,
  input  logic                 npor,
  input  logic                 wren_a,
  input  logic [WIDTHAD_A-1:0] address_a,
  input  logic [WIDTH_A-1:0]   data_a,
  input  logic                 rden_b,
  input  logic                 addressstall_b,
  input  logic [WIDTHAD_B-1:0] address_b,
  output logic [WIDTH_B-1:0]   q_b
);
  logic [WIDTH_A-1:0]   mem [2**WIDTHAD_A];
  logic [WIDTHAD_B-1:0] addr_b_d, addr_b_q;
  logic [WIDTH_B-1:0]   q_d, q_q, rd_word;
  logic [WIDTH_A-1:0]   word;
  if (!((WIDTH_B == WIDTH_A || 2*WIDTH_B == WIDTH_A) &&
        WIDTH_A*(2**WIDTHAD_A) == WIDTH_B*(2**WIDTHAD_B))) begin : g_bad
    $error("phasefifo_dpram: illegal width/depth parameter combination");
  end
  // Array is deliberately outside the reset domain: contents survive npor.
  always_ff @(posedge clock0)
    if (wren_a) mem[address_a] <= data_a;
  if (WIDTH_B == WIDTH_A) begin : g_eq
    assign word    = mem[addr_b_q];
    assign rd_word = word;
  end else begin : g_half
    assign word    = mem[addr_b_q[WIDTHAD_B-1:1]];
    assign rd_word = addr_b_q[0] ? word[WIDTH_A-1:WIDTH_B] : word[WIDTH_B-1:0];
  end
  always_comb begin
    addr_b_d = addressstall_b ? addr_b_q : address_b;
    q_d      = rden_b ? rd_word : q_q;
  end
  always_ff @(posedge clock0 or negedge npor)
    if (!npor) begin
      addr_b_q <= '0;
      q_q      <= '0;
    end else begin
      addr_b_q <= addr_b_d;
      q_q      <= q_d;
    end
  // Unregistered mode: q_q only remembers the last enabled read for hold.
  if (OUTDATA_REG_B != 0) begin : g_oreg
    assign q_b = q_q;
  end else begin : g_ocomb
    assign q_b = npor ? q_d : '0;
  end
endmodule

// File: tb/tb_phasefifo_dpram.sv
// tb_phasefifo_dpram: directed checks of equal- and half-width instances against a bench model
module tb_phasefifo_dpram;
  logic        clock0 = 1'b0, npor = 1'b1, wren_a = 1'b0, rden_b = 1'b0, addressstall_b = 1'b0;
  logic [3:0]  address_a = '0, address_b = '0;
  logic [19:0] data_a = '0;
  logic [19:0] q_b;
  logic [9:0]  q_h;
  int n_chk = 0, n_fail = 0;

  always #5 clock0 = ~clock0;

  phasefifo_dpram u_dut (
    .clock0(clock0), .npor(npor), .wren_a(wren_a), .address_a(address_a), .data_a(data_a),
    .rden_b(rden_b), .addressstall_b(addressstall_b), .address_b(address_b), .q_b(q_b)
  );

  phasefifo_dpram #(.WIDTH_A(20), .WIDTHAD_A(3), .WIDTH_B(10), .WIDTHAD_B(4), .OUTDATA_REG_B(1)) u_half (
    .clock0(clock0), .npor(npor), .wren_a(wren_a), .address_a(address_a[2:0]), .data_a(data_a),
    .rden_b(rden_b), .addressstall_b(addressstall_b), .address_b(address_b), .q_b(q_h)
  );

  task automatic chk(input string name, input logic [19:0] act, input logic [19:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a word array plus "which address was last latched" and "what the output shows"
  logic [19:0] m_mem [16];
  logic [19:0] h_mem [8];
  logic [3:0]  m_addr = '0;
  logic [19:0] m_q = '0, hw;
  logic [9:0]  h_q = '0;

  always @(posedge clock0)
    if (wren_a) begin
      m_mem[address_a]      <= data_a;
      h_mem[address_a[2:0]] <= data_a;
    end

  always @(posedge clock0 or negedge npor)
    if (!npor) begin
      m_q = '0; h_q = '0; m_addr = '0;
    end else begin
      if (rden_b) begin
        m_q = m_mem[m_addr];
        hw  = h_mem[m_addr[3:1]];
        h_q = m_addr[0] ? hw[19:10] : hw[9:0];
      end
      if (!addressstall_b) m_addr = address_b;
    end

  always @(negedge clock0) begin
    if (!$isunknown(m_q)) chk("model_eq", q_b, m_q);
    if (!$isunknown(h_q)) chk("model_half", {10'b0, q_h}, {10'b0, h_q});
  end

  task automatic step;
    @(posedge clock0);
    #1;
  endtask

  function automatic logic [19:0] f(input int c);
    return 20'(c * 37 + 5);
  endfunction

  initial begin
    #2 npor = 1'b0;
    #1 chk("reset_q", q_b, 20'h0);
    repeat (2) step;
    chk("reset_hold", q_b, 20'h0);
    @(negedge clock0);
    npor = 1'b1;
    for (int i = 0; i < 16; i++) begin
      step;
      wren_a = 1'b1; address_a = 4'(i); data_a = 20'(i * 'h111);
    end
    step;
    wren_a = 1'b0;
    chk("after_reset", q_b, 20'h0);
    rden_b = 1'b1;
    for (int j = 0; j < 18; j++) begin
      step;
      if (j >= 2) chk("sweep", q_b, 20'((j - 2) * 'h111));
      address_b = 4'(j);
    end
    step;
    wren_a = 1'b1; address_a = 4'd2; data_a = 20'hABCDE; address_b = 4'd4;
    step;
    wren_a = 1'b0; address_b = 4'd5;
    step;
    chk("half_lo", {10'b0, q_h}, 20'h000DE);
    step;
    chk("half_hi", {10'b0, q_h}, 20'h002AF);
    wren_a = 1'b1; address_a = 4'd5; data_a = 20'h11111; address_b = 4'd5;
    step;
    wren_a = 1'b0;
    step;
    wren_a = 1'b1; data_a = 20'h22222;
    step;
    chk("rdw_old", q_b, 20'h11111);
    wren_a = 1'b0;
    step;
    chk("rdw_new", q_b, 20'h22222);
    address_b = 4'd3;
    repeat (2) step;
    chk("pre_stall", q_b, 20'h00333);
    addressstall_b = 1'b1; address_b = 4'd7;
    repeat (2) step;
    chk("stall", q_b, 20'h00333);
    rden_b = 1'b0; addressstall_b = 1'b0; address_b = 4'd9;
    repeat (2) step;
    chk("rden_hold", q_b, 20'h00333);
    rden_b = 1'b1; address_b = 4'd6;
    repeat (2) step;
    chk("pre_rst", q_b, 20'h00666);
    address_b = 4'd7;
    step;
    npor = 1'b0;
    #2 chk("async_rst", q_b, 20'h0);
    #4 npor = 1'b1;
    step;
    address_b = 4'd3;
    repeat (2) step;
    chk("post_rst", q_b, 20'h00333);
    for (int c = 0; c < 1600; c++) begin
      step;
      if (c >= 6) chk("fifo", q_b, f(c - 6));
      wren_a = 1'b1; address_a = 4'(c + 4); data_a = f(c); address_b = 4'(c);
    end
    step;
    wren_a = 1'b0; rden_b = 1'b0;
    repeat (3) step;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
